// File: rtl/code_seq_pkg.sv
// Shared constants and FSM encoding for the code sequencer.
package code_seq_pkg;

    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE_MAX = 3'd7;
    localparam logic [CODE_W-1:0] CODE_MIN = 3'd0;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;

endpackage

// File: rtl/code_sequencer_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for a raw push-button.
// Emits a single registered pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rawIn,
    output logic pressPulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= rawIn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_pulse <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressPulse = r_pulse;

endmodule

// File: rtl/code_sequencer.sv
// 3-bit up/down code sequencer with manual (debounced button) and
// auto (prescaled tick) stepping, plus a one-cycle wrap strobe.
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btnStep,
    input  logic              modeAuto,
    input  logic              dirDown,
    input  logic              enable,
    output logic [CODE_W-1:0] codeOut,
    output logic              wrapPulse
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_presc;
    logic [CODE_W-1:0] r_code;
    logic              r_wrap;

    logic              w_press;
    logic              w_tick;
    logic              w_step;
    logic              w_wrap;
    logic [CODE_W-1:0] w_code_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .rawIn     (btnStep),
        .pressPulse(w_press)
    );

    always_comb begin
        w_next = ST_PAUSE;
        unique case (1'b1)
            !enable:             w_next = ST_PAUSE;
            enable &&  modeAuto: w_next = ST_AUTO;
            enable && !modeAuto: w_next = ST_MANUAL;
            default:             w_next = ST_PAUSE;
        endcase
    end

    always_comb begin
        w_tick     = (r_state == ST_AUTO) && (r_presc == PRESC_LAST);
        w_step     = w_tick || ((r_state == ST_MANUAL) && w_press);
        w_code_nxt = dirDown ? (r_code - 1'b1) : (r_code + 1'b1);
        w_wrap     = dirDown ? (r_code == CODE_MIN) : (r_code == CODE_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PAUSE;
        end else begin
            r_state <= w_next;
        end
    end

    // Prescaler restarts on every state change so AUTO entry is aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_next != r_state) begin
            r_presc <= '0;
        end else if (r_state == ST_AUTO) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end else begin
            r_presc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= CODE_MIN;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_step && w_wrap;
            if (w_step) begin
                r_code <= w_code_nxt;
            end
        end
    end

    assign codeOut   = r_code;
    assign wrapPulse = r_wrap;

endmodule

// File: tb/tb_code_sequencer.sv
// Randomized scoreboard bench for code_sequencer against a behavioural model.
module tb_code_sequencer;

    localparam int NDB  = 4;
    localparam int TICK = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btnStep;
    logic       modeAuto;
    logic       dirDown;
    logic       enable;
    logic [2:0] codeOut;
    logic       wrapPulse;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    code_sequencer #(
        .DEBOUNCE_CYCLES(NDB),
        .TICK_DIV       (TICK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btnStep  (btnStep),
        .modeAuto (modeAuto),
        .dirDown  (dirDown),
        .enable   (enable),
        .codeOut  (codeOut),
        .wrapPulse(wrapPulse)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [3:0] act, logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t got code=%0d wrap=%b want code=%0d wrap=%b",
                     nm, $time, act[3:1], act[0], want[3:1], want[0]);
        end
    endtask

    // Behavioural model: modes 0=pause 1=manual 2=auto
    bit   m_s1, m_s2, m_lvl, m_press, m_wrap;
    bit   m_hist[$];
    int   m_mode, m_age;
    int   m_code;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_wrap = 0;
            m_hist.delete();
            m_mode = 0; m_age = 0; m_code = 0;
        end else begin
            bit stepnow, flip, allDiff;
            int want_mode;
            want_mode = !enable ? 0 : (modeAuto ? 2 : 1);
            stepnow = (m_mode == 1 && m_press) ||
                      (m_mode == 2 && m_age == TICK - 1);
            m_wrap = 0;
            if (stepnow) begin
                m_wrap = dirDown ? (m_code == 0) : (m_code == 7);
                m_code = dirDown ? (m_code + 7) % 8 : (m_code + 1) % 8;
            end
            if (want_mode != m_mode) m_age = 0;
            else if (m_mode == 2) m_age = (m_age + 1) % TICK;
            else m_age = 0;
            m_mode = want_mode;
            // Level flips once the last NDB synchronized samples all disagree
            m_hist.push_back(m_s2);
            if (m_hist.size() > NDB) void'(m_hist.pop_front());
            allDiff = (m_hist.size() == NDB);
            foreach (m_hist[i]) if (m_hist[i] == m_lvl) allDiff = 0;
            flip = allDiff;
            m_press = flip && !m_lvl;
            if (flip) m_lvl = !m_lvl;
            m_s2 = m_s1;
            m_s1 = btnStep;
        end
        exp_q.push_back({m_code[2:0], m_wrap});
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty t=%0t got code=%0d want entry",
                     $time, codeOut);
        end else begin
            check("cycle", {codeOut, wrapPulse}, exp_q.pop_front());
        end
    end

    task automatic hold(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        #1;
        check("async_reset", {codeOut, wrapPulse}, 4'b0000);
        hold(n);
        rst_n = 1'b1;
    endtask

    task automatic press(int hi, int lo);
        btnStep = 1'b1;
        hold(hi);
        btnStep = 1'b0;
        hold(lo);
    endtask

    initial begin
        rst_n = 1'b0;
        btnStep = 1'b0;
        modeAuto = 1'b0;
        dirDown = 1'b0;
        enable = 1'b0;
        hold(3);
        check("reset_state", {codeOut, wrapPulse}, 4'b0000);
        rst_n = 1'b1;
        enable = 1'b1;
        hold(2);
        press(10, 10);
        for (int i = 0; i < 4; i++) begin
            btnStep = ~btnStep;
            hold(1);
        end
        press(10, 10);
        press(3, 10);
        for (int i = 0; i < 4; i++) press(10, 8);
        modeAuto = 1'b1;
        hold(22);
        dirDown = 1'b1;
        hold(4);
        press(8, 12);
        enable = 1'b0;
        hold(6);
        enable = 1'b1;
        hold(12);
        modeAuto = 1'b0;
        dirDown = 1'b0;
        hold(2);
        btnStep = 1'b1;
        hold(4);
        do_reset(2);
        hold(12);
        btnStep = 1'b0;
        hold(6);
        press(10, 10);
        for (int ph = 0; ph < 400; ph++) begin
            case ($urandom_range(0, 19))
                0: do_reset($urandom_range(1, 3));
                1, 2, 3: begin
                    enable   = 1'($urandom_range(0, 3) != 0);
                    modeAuto = 1'($urandom_range(0, 1));
                    hold($urandom_range(1, 15));
                end
                4, 5: begin
                    dirDown = 1'($urandom_range(0, 1));
                    hold($urandom_range(1, 6));
                end
                6, 7, 8: begin
                    for (int k = $urandom_range(1, 6); k > 0; k--) begin
                        btnStep = 1'($urandom_range(0, 1));
                        hold(1);
                    end
                end
                default: press($urandom_range(1, 12), $urandom_range(1, 12));
            endcase
        end
        btnStep = 1'b0;
        hold(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, equal to the number of consecutive stable synchronized samples required to accept a button level change (minimum 2).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000000, equal to the number of clock cycles per auto-step (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btnStep, input, 1 bit: raw, asynchronous, bouncing push-button.
REQ-006 The block SHALL have port modeAuto, input, 1 bit, synchronous: 1 selects auto-run, 0 selects manual stepping.
REQ-007 The block SHALL have port dirDown, input, 1 bit, synchronous: 1 counts down, 0 counts up.
REQ-008 The block SHALL have port enable, input, 1 bit, synchronous: 0 freezes the code.
REQ-009 The block SHALL have port codeOut, output, 3 bits: registered code that feeds the downstream 3-to-8 decoder codeIn.
REQ-010 The block SHALL have port wrapPulse, output, 1 bit: one-cycle strobe on code wrap.

Function
REQ-011 btnStep SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounced level SHALL toggle only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample SHALL clear the debounce counter.
REQ-013 A 0->1 transition of the debounced level SHALL produce one step request; a 1->0 transition SHALL produce none.
REQ-014 The FSM states SHALL be PAUSE, MANUAL and AUTO.
REQ-015 FSM transitions SHALL be evaluated every cycle: enable=0 -> PAUSE; enable=1 and modeAuto=1 -> AUTO; enable=1 and modeAuto=0 -> MANUAL.
REQ-016 In MANUAL, each step request SHALL change codeOut on the clock edge after the debounced rise.
REQ-017 In AUTO, the prescaler SHALL count 0..TICK_DIV-1 and step codeOut on the edge where it wraps to 0, giving one step every TICK_DIV cycles.
REQ-018 In AUTO, button step requests SHALL be ignored.
REQ-019 In PAUSE, codeOut, the prescaler and wrapPulse SHALL hold or read 0 as follows: codeOut holds, the prescaler holds at 0, wrapPulse=0, and button requests are discarded.
REQ-020 Any state change SHALL clear the prescaler to 0, so the first auto-step comes TICK_DIV cycles after entering AUTO.
REQ-021 A step SHALL add 1 (dirDown=0) or subtract 1 (dirDown=1) modulo 8.
REQ-022 A step taking 7->0 (up) or 0->7 (down) SHALL assert wrapPulse for exactly the cycle in which the new codeOut is first visible.
REQ-023 At most one step SHALL occur per cycle regardless of simultaneous events.
REQ-024 A dirDown change SHALL affect only the next step, never the current code.
REQ-025 The debouncer SHALL keep running in all states, so that a press held across a state change yields no spurious step afterwards.

Reset
REQ-026 While rst_n=0: codeOut=3'b000, wrapPulse=0, FSM=PAUSE, prescaler=0, debounce counter=0, synchronizer flops and debounced level=0.
REQ-027 Reset assertion SHALL take effect immediately, mid-step or mid-debounce, with no partial step.
REQ-028 Release SHALL be synchronous to clk; the FSM SHALL enter its enable/modeAuto state on the first edge after release.

Structure
REQ-029 A shared package SHALL hold the code width constant (3), the FSM state encoding, and the wrap boundary values.
REQ-030 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, with ports clk, rst_n, rawIn and pressPulse.
REQ-031 The implementation SHALL be 120-400 lines of RTL.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5)
REQ-032 Reset then enable=1, modeAuto=0: clean btnStep pulse of 10 cycles -> exactly one step, codeOut 0->1, wrapPulse=0.
REQ-033 Bounce 1,0,1,0 at 1-cycle spacing, then high for 10 cycles -> exactly one step; a high of only 3 cycles -> no step.
REQ-034 modeAuto=1, dirDown=0, from code 6 -> steps every 5 cycles: 7, 0, 1; wrapPulse=1 only in the cycle codeOut becomes 0.
REQ-035 AUTO, dirDown=1, from code 1 -> 0, 7 with wrapPulse on 7; a button press meanwhile -> no extra step.
REQ-036 enable=0 in AUTO 2 cycles before a tick -> codeOut frozen; re-enable -> next step exactly 5 cycles later.
REQ-037 rst_n pulsed low mid-debounce at code 5 -> codeOut=0 immediately; no step after release until a fresh full press.
